// File: rtl/display_scan_mux.sv
// display_scan_mux: round-robin digit scanner with registered value/anode outputs.
// Optional build macro ZERO_BLANK_EN enables leading-zero suppression.
`default_nettype none

module display_scan_mux #(
    parameter int N_CH = 4,
    parameter int W    = 4,
    parameter int DIV  = 100000,
    localparam int SW  = $clog2(N_CH),
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [N_CH*W-1:0]   data,
    input  logic [N_CH-1:0]     blank,
    output logic [SW-1:0]       sel,
    output logic [W-1:0]        y,
    output logic [N_CH-1:0]     an,
    output logic                tick
);

    localparam logic [CW-1:0] C_CNT_LAST = CW'(DIV - 1);
    localparam logic [SW-1:0] C_SEL_LAST = SW'(N_CH - 1);

    logic [CW-1:0]   r_cnt;
    logic            w_slot_end;
    logic            w_last_ch;
    logic [W-1:0]    w_cur;
    logic [N_CH-1:0] w_zb;
    logic [N_CH-1:0] w_an_next;

    assign w_slot_end = (r_cnt == C_CNT_LAST);
    assign w_last_ch  = (sel == C_SEL_LAST);

`ifdef ZERO_BLANK_EN
    // Walk from the top channel down; a channel is suppressed while everything
    // at and above it is zero. Channel 0 always stays visible.
    always_comb begin
        logic w_zero_above;
        w_zero_above = 1'b1;
        w_zb         = '0;
        for (int k = N_CH - 1; k >= 1; k--) begin
            w_zero_above = w_zero_above & (data[k*W +: W] == '0);
            w_zb[k]      = w_zero_above;
        end
    end
`else
    assign w_zb = '0;
`endif

    // Decode by comparison rather than variable slicing so a non-power-of-2
    // channel count can never address past the top of data.
    always_comb begin
        w_cur     = '0;
        w_an_next = '1;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SW'(k)) begin
                w_cur = data[k*W +: W];
                if (en && !blank[k] && !w_zb[k]) begin
                    w_an_next[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            sel   <= '0;
            y     <= '0;
            an    <= '1;
            tick  <= 1'b0;
        end else begin
            y    <= w_cur;
            an   <= w_an_next;
            tick <= en && w_slot_end && w_last_ch;
            if (en) begin
                if (w_slot_end) begin
                    r_cnt <= '0;
                    sel   <= w_last_ch ? '0 : sel + 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: scoreboard bench for display_scan_mux (4x4/DIV=4 and 3x4/DIV=1 instances).
`default_nettype none

module tb_display_scan_mux;

    typedef struct {
        int sel;
        int y;
        int an;
        int tick;
    } exp_t;

    logic clk;
    logic rst, rst_b;

    logic        en_a;
    logic [15:0] data_a;
    logic [3:0]  blank_a;
    logic [1:0]  sel_a;
    logic [3:0]  y_a;
    logic [3:0]  an_a;
    logic        tick_a;

    logic        en_b;
    logic [11:0] data_b;
    logic [2:0]  blank_b;
    logic [1:0]  sel_b;
    logic [3:0]  y_b;
    logic [2:0]  an_b;
    logic        tick_b;

    int n_chk  = 0;
    int n_pass = 0;
    int ms_a = 0, mc_a = 0;
    int ms_b = 0, mc_b = 0;
    int n_tick = 0;
    int y_seen[$];
    exp_t sb[$];

    display_scan_mux #(.N_CH(4), .W(4), .DIV(4)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .data(data_a), .blank(blank_a),
        .sel(sel_a), .y(y_a), .an(an_a), .tick(tick_a)
    );

    display_scan_mux #(.N_CH(3), .W(4), .DIV(1)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .data(data_b), .blank(blank_b),
        .sel(sel_b), .y(y_b), .an(an_b), .tick(tick_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Behavioural reference: what the outputs should read after the next edge,
    // and the scan position that edge leaves behind.
    task automatic model_step(input int n, input int w, input int div,
                              input logic [63:0] d, input logic [7:0] bl, input logic e,
                              inout int s, inout int c, output exp_t x);
        logic [63:0] mask;
        logic        lit;
        mask = (64'd1 << w) - 64'd1;
        x.y  = int'((d >> (s * w)) & mask);
        lit  = e && !bl[s];
`ifdef ZERO_BLANK_EN
        if (s > 0) begin
            bit all_zero;
            all_zero = 1'b1;
            for (int j = s; j < n; j++)
                if (((d >> (j * w)) & mask) != 64'd0) all_zero = 1'b0;
            if (all_zero) lit = 1'b0;
        end
`endif
        x.an = (1 << n) - 1;
        if (lit) x.an = x.an & ~(1 << s);
        x.tick = (e && c == div - 1 && s == n - 1) ? 1 : 0;
        if (e) begin
            if (c == div - 1) begin
                c = 0;
                s = (s + 1) % n;
            end else begin
                c = c + 1;
            end
        end
        x.sel = s;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic step(input bit use_b);
        exp_t e;
        if (use_b) model_step(3, 4, 1, {52'd0, data_b}, {5'd0, blank_b}, en_b, ms_b, mc_b, e);
        else       model_step(4, 4, 4, {48'd0, data_a}, {4'd0, blank_a}, en_a, ms_a, mc_a, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (use_b) begin
            check("b_sel", sel_b, e.sel);
            check("b_y", y_b, e.y);
            check("b_an", an_b, e.an);
            check("b_tick", tick_b, e.tick);
            n_tick += int'(tick_b);
            y_seen.push_back(int'(y_b));
        end else begin
            check("a_sel", sel_a, e.sel);
            check("a_y", y_a, e.y);
            check("a_an", an_a, e.an);
            check("a_tick", tick_a, e.tick);
            n_tick += int'(tick_a);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_sel"}, sel_a, 0);
        check({tag, "_y"}, y_a, 0);
        check({tag, "_an"}, an_a, 4'hF);
        check({tag, "_tick"}, tick_a, 0);
    endtask

    initial begin
        int ylist[3];
        rst = 1'b1; rst_b = 1'b1;
        en_a = 1'b0; data_a = '0; blank_a = '0;
        en_b = 1'b0; data_b = '0; blank_b = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_a("rst0");
        rst = 1'b0;

        // Scan: 25 edges ends mid-slot with sel=2, cnt=1; one wrap in that span.
        data_a = 16'h4321; en_a = 1'b1;
        n_tick = 0;
        for (int i = 0; i < 25; i++) step(1'b0);
        check("scan_tick_count", n_tick, 1);
        check("scan_sel_mid", sel_a, 2);

        // Asynchronous reset away from any clock edge.
        #2 rst = 1'b1;
        #1 check_reset_a("rst_mid");
        @(negedge clk);
        rst = 1'b0; ms_a = 0; mc_a = 0;

        // Freeze at sel=1, cnt=2 then resume.
        for (int i = 0; i < 6; i++) step(1'b0);
        en_a = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b0);
        check("freeze_sel_hold", sel_a, 1);
        en_a = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0);

        // Per-channel force blank.
        blank_a = 4'b0100;
        for (int i = 0; i < 16; i++) step(1'b0);
        blank_a = '0;

        // Leading-zero patterns (suppressed only when ZERO_BLANK_EN is built in).
        data_a = 16'h0070;
        for (int i = 0; i < 16; i++) step(1'b0);
        data_a = 16'h0000;
        for (int i = 0; i < 16; i++) step(1'b0);

        // Mixed random traffic including mid-slot data and enable changes.
        for (int i = 0; i < 40; i++) begin
            data_a  = 16'($urandom);
            blank_a = 4'($urandom_range(0, 15));
            en_a    = ($urandom_range(0, 3) != 0);
            step(1'b0);
        end

        // Three channels, one clock per slot.
        rst_b = 1'b0; data_b = 12'hABC; en_b = 1'b1;
        n_tick = 0;
        y_seen.delete();
        for (int i = 0; i < 9; i++) step(1'b1);
        check("b_tick_count", n_tick, 3);
        ylist[0] = 'hC; ylist[1] = 'hB; ylist[2] = 'hA;
        for (int i = 0; i < 9; i++) check("b_y_order", y_seen[i], ylist[i % 3]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
